// File: rtl/alu_nibble_sequencer_if.sv
// Request, response and ALU-side signals of the nibble sequencer.
// The sequencer uses the slave modport; requester/consumer/ALU model uses master.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_sel;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;

  logic [1:0]   alu_sel;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         busy;

  modport slave (
    input  req_valid, req_sel, req_a, req_b, req_cin, alu_f, alu_cout, rsp_ready,
    output req_ready, alu_sel, alu_a, alu_b, alu_cin, rsp_valid, rsp_f, rsp_cout,
           rsp_zero, busy
  );

  modport master (
    output req_valid, req_sel, req_a, req_b, req_cin, alu_f, alu_cout, rsp_ready,
    input  req_ready, alu_sel, alu_a, alu_b, alu_cin, rsp_valid, rsp_f, rsp_cout,
           rsp_zero, busy
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a W-bit operation through an external 4-bit ALU, one nibble per cycle,
// LSB first, chaining the carry through a flop. NIBBLES must match the interface.
//
//   state | meaning
//   IDLE  | ready for a request, ALU inputs held at 0
//   RUN   | feeding nibble idx to the ALU, capturing its result and carry
//   DONE  | response presented, waiting for rsp_ready
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_nibble_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [1:0]    sel_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  r_q;
  logic          rsp_valid_q;
  logic          rsp_cout_q;
  logic          rsp_zero_q;

  logic [IW+1:0] sh;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [W-1:0]  r_next;
  logic          run;

  assign run    = (state == RUN);
  assign sh     = {idx, 2'b00};
  assign nib_a  = 4'(a_q >> sh);
  assign nib_b  = 4'(b_q >> sh);
  // Current result with the nibble at idx replaced by the ALU output.
  assign r_next = (r_q & ~(W'(4'hF) << sh)) | (W'(bus.alu_f) << sh);

  assign bus.req_ready = rst_n && (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.alu_sel   = run ? sel_q : 2'b00;
  assign bus.alu_a     = run ? nib_a : 4'h0;
  assign bus.alu_b     = run ? nib_b : 4'h0;
  assign bus.alu_cin   = run ? carry : 1'b0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_f     = r_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_zero  = rsp_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      sel_q       <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sel_q <= bus.req_sel;
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            carry <= bus.req_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          r_q   <= r_next;
          carry <= bus.alu_cout;
          idx   <= idx + IW'(1);
          if (idx == IW'(NIBBLES - 1)) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_cout_q  <= bus.alu_cout;
            rsp_zero_q  <= (r_next == '0);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
